// File: rtl/regfile_dump_if.sv
// Bundle of the dump sequencer's control, register-file read port and byte stream.
interface regfile_dump_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) ();
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_last;
  logic              busy;
  logic              done;

  // The dump sequencer drives the read address and the byte stream.
  modport master (
    input  start, abort, start_addr, end_addr, rd_data, tx_ready,
    output rd_addr, tx_data, tx_valid, tx_last, busy, done
  );

  // The environment: requester, register file and byte sink.
  modport slave (
    output start, abort, start_addr, end_addr, rd_data, tx_ready,
    input  rd_addr, tx_data, tx_valid, tx_last, busy, done
  );
endinterface

// File: rtl/regfile_dump.sv
// Register-file dump sequencer: walks an address range (with wrap) through the
// register-file read port and streams each word out as big-endian bytes.
module regfile_dump #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input logic             clk,
  input logic             rst,
  regfile_dump_if.master  bus
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] stop_q, stop_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_last_q, tx_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hs_c;

  // A byte leaves when it is offered and the sink takes it.
  assign hs_c = tx_valid_q && bus.tx_ready;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cur_d   = bus.start_addr;
          stop_d  = bus.end_addr;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        shift_d = bus.rd_data;
        cnt_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (hs_c) begin
          shift_d = shift_q << 8;
          if (cnt_q == LAST_BYTE) begin
            cnt_d = '0;
            if (cur_q == stop_q) begin
              state_d = S_DONE;
            end else begin
              cur_d   = cur_q + ADDR_W'(1);
              state_d = S_LOAD;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Cancel beats any start, load or handshake in the same cycle.
    if (bus.abort) begin
      state_d = S_IDLE;
    end

    tx_valid_d = (state_d == S_SEND);
    busy_d     = (state_d == S_LOAD) || (state_d == S_SEND);
    done_d     = (state_d == S_DONE);
    tx_last_d  = (state_d == S_SEND) && (cnt_d == LAST_BYTE) && (cur_d == stop_d);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      stop_q     <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      stop_q     <= stop_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.rd_addr  = cur_q;
  assign bus.tx_data  = shift_q[DATA_W-1 -: 8];
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_last  = tx_last_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: queue-based byte-stream model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_regfile_dump;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_dump_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_dump #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Register file model; r0 is hard zero.
  logic [31:0] rf [32];
  assign bus.rd_data = rf[bus.rd_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0] addr;
    logic [7:0] b;
  } item_t;

  // Model: pending bytes of the current dump, plus per-cycle expectations.
  item_t exp_q[$];
  bit    mbusy = 0, mload = 0, mdone = 0;

  // Observation logs for the directed checks.
  logic [7:0] rx_log[$];
  bit         last_log[$];
  logic [4:0] addr_log[$];
  int         busy_cnt = 0, done_cnt = 0, cyc = 0, t_load = 0, t_done = 0;
  bit         load_seen = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic build_queue(input logic [4:0] sa, input logic [4:0] ea);
    logic [4:0]  a;
    logic [31:0] w;
    item_t       it;
    a = sa;
    for (int n = 0; n < 32; n++) begin
      w = rf[a];
      for (int k = 0; k < 4; k++) begin
        it.addr = a;
        it.b    = w[31:24];
        exp_q.push_back(it);
        w = w << 8;
      end
      if (a == ea) break;
      a = a + 5'd1;
    end
  endtask

  // Per-cycle compare against the model, then advance the model and logs.
  always @(negedge clk) begin
    bit nbusy, nload, ndone, hs;
    cyc++;
    if (rst) begin
      exp_q.delete();
      mbusy = 0; mload = 0; mdone = 0;
    end
    chk("busy", bus.busy, mbusy);
    chk("done", bus.done, mdone);
    chk("tx_valid", bus.tx_valid, mbusy && !mload);
    if (mbusy) begin
      if (exp_q.size() == 0) chk("model_queue", 0, 1);
      else begin
        chk("rd_addr", bus.rd_addr, exp_q[0].addr);
        if (!mload) begin
          chk("tx_data", bus.tx_data, exp_q[0].b);
          chk("tx_last", bus.tx_last, exp_q.size() == 1);
        end
      end
    end else begin
      chk("tx_last_idle", bus.tx_last, 0);
    end
    if (prev_stall) begin
      chk("stall_valid", bus.tx_valid, 1);
      chk("stall_data", bus.tx_data, prev_data);
      chk("stall_last", bus.tx_last, prev_last);
    end

    // Logs of what the DUT actually did.
    if (bus.busy) busy_cnt++;
    if (bus.busy && !load_seen) begin load_seen = 1; t_load = cyc; end
    if (bus.done) begin done_cnt++; t_done = cyc; end
    if (bus.busy && !bus.tx_valid) addr_log.push_back(bus.rd_addr);
    if (bus.tx_valid && bus.tx_ready && !bus.abort && !rst) begin
      rx_log.push_back(bus.tx_data);
      last_log.push_back(bus.tx_last);
    end
    prev_stall = bus.tx_valid && !bus.tx_ready && !bus.abort && !rst;
    prev_data  = bus.tx_data;
    prev_last  = bus.tx_last;

    // Model advance for the coming edge.
    if (!rst) begin
      nbusy = mbusy; nload = 0; ndone = 0;
      hs = mbusy && !mload && bus.tx_ready;
      if (bus.abort) begin
        nbusy = 0;
        exp_q.delete();
      end else if (!mbusy && !mdone) begin
        if (bus.start) begin
          build_queue(bus.start_addr, bus.end_addr);
          nbusy = 1;
          nload = 1;
        end
      end else if (hs && exp_q.size() > 0) begin
        if (exp_q.size() == 1) begin
          nbusy = 0;
          ndone = 1;
        end else if (exp_q.size() % 4 == 1) begin
          nload = 1;
        end
        exp_q.delete(0);
      end
      mbusy = nbusy; mload = nload; mdone = ndone;
    end
  end

  task automatic clear_logs();
    rx_log.delete(); last_log.delete(); addr_log.delete();
    busy_cnt = 0; done_cnt = 0; load_seen = 0; t_load = 0; t_done = 0;
  endtask

  task automatic do_start(input logic [4:0] sa, input logic [4:0] ea);
    @(posedge clk); #1;
    bus.start_addr = sa;
    bus.end_addr   = ea;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit toggle);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      @(posedge clk); #1;
      if (toggle) bus.tx_ready = ~bus.tx_ready;
      n++;
    end
    chk("done_seen", done_cnt > 0, 1);
    bus.tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_bytes(input string name, input logic [7:0] e[$]);
    chk({name, "_count"}, rx_log.size(), e.size());
    for (int i = 0; i < e.size() && i < rx_log.size(); i++)
      chk(name, rx_log[i], e[i]);
  endtask

  initial begin
    logic [7:0] e[$];
    int n;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    bus.start = 0; bus.abort = 0; bus.start_addr = '0; bus.end_addr = '0;
    bus.tx_ready = 1'b1;
    #1;
    // Reset values while rst is held.
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_busy", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Two words, sink always ready.
    rf[5] = 32'h11223344; rf[6] = 32'hAABBCCDD;
    clear_logs();
    do_start(5'd5, 5'd6);
    wait_done(60, 0);
    e = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    chk_bytes("t1_byte", e);
    n = 0;
    foreach (last_log[i]) if (last_log[i]) n++;
    chk("t1_last_count", n, 1);
    chk("t1_last_on_dd", last_log.size() == 8 && last_log[7], 1);
    chk("t1_busy_cycles", busy_cnt, 10);
    chk("t1_load_to_done", t_done - t_load, 10);
    chk("t1_done_count", done_cnt, 1);

    // Wrapping range 30..1, r0 reads zero.
    for (int i = 1; i < 32; i++) rf[i] = 32'(i);
    clear_logs();
    do_start(5'd30, 5'd1);
    wait_done(100, 0);
    e = '{0, 0, 0, 8'd30, 0, 0, 0, 8'd31, 0, 0, 0, 0, 0, 0, 0, 8'd1};
    chk_bytes("t2_byte", e);
    chk("t2_addr_count", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("t2_addr0", addr_log[0], 30);
      chk("t2_addr1", addr_log[1], 31);
      chk("t2_addr2", addr_log[2], 0);
      chk("t2_addr3", addr_log[3], 1);
    end

    // Single word with sink toggling ready every cycle.
    rf[7] = 32'hDEADBEEF;
    clear_logs();
    do_start(5'd7, 5'd7);
    wait_done(60, 1);
    e = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    chk_bytes("t3_byte", e);
    chk("t3_last_on_ef", last_log.size() == 4 && last_log[3] && !last_log[2], 1);
    chk("t3_done_count", done_cnt, 1);

    // Full dump with an ignored start while busy.
    for (int i = 1; i < 32; i++) rf[i] = 32'(i) * 32'h01010101 ^ 32'h80402010;
    clear_logs();
    do_start(5'd0, 5'd31);
    repeat (20) @(posedge clk);
    do_start(5'd3, 5'd4);
    wait_done(400, 0);
    chk("t4_byte_count", rx_log.size(), 128);
    chk("t4_load_to_done", t_done - t_load, 160);
    chk("t4_done_count", done_cnt, 1);
    if (rx_log.size() == 128) begin
      chk("t4_first_byte", rx_log[0], 8'h00);
      chk("t4_byte4", rx_log[4], 8'h81);
      chk("t4_final_byte", rx_log[127], 8'h1F ^ 8'h10);
    end

    // Abort after the second byte of a three-word dump, then restart.
    rf[10] = 32'h0A0B0C0D; rf[11] = 32'h1A1B1C1D; rf[12] = 32'h2A2B2C2D;
    clear_logs();
    do_start(5'd10, 5'd12);
    n = 0;
    while (rx_log.size() < 2 && n < 40) begin @(posedge clk); n++; end
    chk("t5_two_bytes", rx_log.size(), 2);
    #1 bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("t5_valid_after_abort", bus.tx_valid, 0);
    chk("t5_busy_after_abort", bus.busy, 0);
    chk("t5_last_after_abort", bus.tx_last, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_no_done", done_cnt, 0);
    rf[20] = 32'hCAFE0114;
    clear_logs();
    do_start(5'd20, 5'd20);
    wait_done(60, 0);
    e = '{8'hCA, 8'hFE, 8'h01, 8'h14};
    chk_bytes("t5_restart_byte", e);

    // start and abort together in IDLE: stay idle.
    @(posedge clk); #1;
    bus.start_addr = 5'd2; bus.end_addr = 5'd2;
    bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("t6_busy", bus.busy, 0);
    @(posedge clk); #1;
    chk("t6_valid", bus.tx_valid, 0);

    // Asynchronous reset mid-SEND.
    clear_logs();
    do_start(5'd0, 5'd3);
    n = 0;
    while (rx_log.size() < 3 && n < 40) begin @(posedge clk); n++; end
    #3;
    chk("t7_valid_before_rst", bus.tx_valid, 1);
    rst = 1'b1;
    #1;
    chk("t7_rd_addr", bus.rd_addr, 0);
    chk("t7_tx_data", bus.tx_data, 0);
    chk("t7_tx_valid", bus.tx_valid, 0);
    chk("t7_tx_last", bus.tx_last, 0);
    chk("t7_busy", bus.busy, 0);
    chk("t7_done", bus.done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t7_idle_busy", bus.busy, 0);
    chk("t7_idle_valid", bus.tx_valid, 0);
    chk("t7_no_done", done_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Register-file dump sequencer: on a start pulse it walks a range of register addresses through a read port of the 32×32 general-purpose register file. It captures each 32-bit word and streams it out as big-endian bytes over a valid/ready byte interface. It is the read-side companion to the register file's write port and sits between the register file and the debug/UART byte link.

## Interface
- ADDR_W, 5, register address width (2**ADDR_W registers)
- DATA_W, 32, register data width; must be a multiple of 8

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle request to begin a dump; ignored unless IDLE
- abort  input  1  synchronous cancel; wins over every other event except rst
- start_addr  input  ADDR_W  first register to dump, sampled when start accepted
- end_addr  input  ADDR_W  last register to dump, sampled when start accepted
- rd_addr  output  ADDR_W  register-file read address (registered)
- rd_data  input  DATA_W  register-file combinational read data for rd_addr
- tx_data  output  8  current byte
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  sink accepts byte when tx_valid && tx_ready at rising edge
- tx_last  output  1  high with final byte of the dump
- busy  output  1  high in LOAD and SEND
- done  output  1  one-cycle pulse after final byte accepted

## Operation
- States: IDLE, LOAD, SEND, DONE.
- IDLE: start=1 → latch cur=start_addr, stop=end_addr, rd_addr=start_addr; go LOAD.
- LOAD (exactly 1 cycle): rd_addr is stable at cur; sample rd_data into shift register at end of cycle; byte_cnt=0; go SEND.
- SEND: tx_valid=1, tx_data=shift[DATA_W-1 -: 8] (MSB byte first). On handshake: shift left 8, byte_cnt+1.
  - On the handshake of the last byte (byte_cnt==DATA_W/8-1):
    - cur==stop → go DONE.
    - Otherwise cur=(cur+1) mod 2**ADDR_W, rd_addr=new cur; go LOAD.
- tx_last = SEND && byte_cnt==DATA_W/8-1 && cur==stop.
- DONE: done=1 for one cycle; go IDLE.
- Word count = ((stop-cur_start) mod 2**ADDR_W)+1.
  - start_addr==end_addr → single word.
  - end_addr<start_addr → wrap through 31 to 0.
- Register 0 is dumped like any other (reads as 0 from the file).
- abort in any non-IDLE state: next cycle IDLE, tx_valid=0, tx_last=0, busy=0, no done pulse. A partially sent word is discarded.
- start while not IDLE: ignored, not queued. start and abort in the same IDLE cycle: abort wins, stay IDLE.

## Timing
- Reset values: rd_addr=0, tx_data=0, tx_valid=0, tx_last=0, busy=0, done=0, state IDLE, internal counters 0.
- rst asserted mid-dump: all outputs go to reset values immediately (asynchronous); sequence restarts only on a new start.
- start accepted at edge k → busy=1 and LOAD during cycle k+1 → tx_valid=1 from edge k+2.
- With tx_ready held high, each word costs 5 cycles (1 LOAD + 4 SEND). A full 32-register dump takes 160 cycles from first LOAD to DONE. done is high in the cycle after the last handshake; busy is low in that cycle.
- tx_valid=1 && tx_ready=0: tx_data and tx_last hold stable; tx_valid never drops without a handshake except on abort or rst.
- tx_valid is 0 during LOAD: one bubble between words.
- rd_addr changes only on entry to LOAD and holds through that word's SEND. The register file writes on the falling edge, so a same-cycle write to cur is captured if it precedes the LOAD sampling edge.

## Test plan
- Regs r5=0x11223344, r6=0xAABBCCDD; start_addr=5, end_addr=6, tx_ready=1 → bytes 11,22,33,44,AA,BB,CC,DD; tx_last only on DD; done one cycle later; 10 busy cycles total.
- start_addr=30, end_addr=1 with r30..r1 loaded with their indices → 4 words in order 30,31,0,1; r0 yields 00 00 00 00; rd_addr sequence 30,31,0,1.
- start_addr=end_addr=7, r7=0xDEADBEEF, tx_ready toggling 1/0 each cycle → DE,AD,BE,EF with tx_data stable through every stall; tx_last on EF; done once.
- Full dump 0..31, tx_ready=1 → 128 bytes; done exactly 160 cycles after the first LOAD cycle. A second start pulsed during busy is ignored.
- abort asserted after the 2nd byte of a 3-word dump → tx_valid=0 and busy=0 next cycle, done never pulses. A new start then dumps from the new start_addr correctly.
- rst asserted while in SEND with tx_valid=1 → all outputs 0 immediately. After rst deasserts, the block stays IDLE until start.
